// File: rtl/bcd_counter_pkg.sv
// Shared BCD counter types and constants.
// Used by the decade stage and the cascade top.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_clamp(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_stage.sv
// One decade digit: load, up/down step with wrap.
// Flags let the top build the carry chain.
module bcd_digit_stage
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t next_digit;

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);

  always_comb begin
    next_digit = digit;
    if (up)
      next_digit = at_max ? BCD_MIN : digit + 4'd1;
    else
      next_digit = at_min ? BCD_MAX : digit - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      digit <= BCD_MIN;
    else if (load)
      digit <= load_digit;
    else if (step_en)
      digit <= next_digit;
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD up/down counter built from decade stages.
// Holds the wrap/saturate policy and the pulse registers.
module bcd_cascade_counter
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit WRAP_EN    = 1'b1
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic                    Start_Stopb_In,
  input  logic                    Up_Downb_In,
  input  logic                    Load_In,
  input  logic [4*NUM_DIGITS-1:0] Load_Value_In,
  output logic [4*NUM_DIGITS-1:0] Count_Out,
  output logic                    Carry_Out,
  output logic                    Terminal_Out,
  output logic                    Load_Error_Out
);

  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_min;
  logic [NUM_DIGITS-1:0] step_en;
  logic [NUM_DIGITS-1:0] ovr;
  logic                  terminal;
  logic                  count_en;
  logic                  carry_q;
  logic                  lerr_q;

  assign terminal = Up_Downb_In ? &at_max : &at_min;
  // Saturating build suppresses the step that would wrap.
  assign count_en = Start_Stopb_In & (WRAP_EN | ~terminal);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_t ld;
    logic       lo_max;
    logic       lo_min;

    assign ld     = bcd_clamp(Load_Value_In[4*i +: 4]);
    assign ovr[i] = (Load_Value_In[4*i +: 4] > BCD_MAX);

    if (i == 0) begin : g_lsd
      assign lo_max = 1'b1;
      assign lo_min = 1'b1;
    end else begin : g_upper
      assign lo_max = &at_max[i-1:0];
      assign lo_min = &at_min[i-1:0];
    end

    assign step_en[i] = count_en &
                        (Up_Downb_In ? lo_max : lo_min);

    bcd_digit_stage u_stage (
      .clk        (Clk_In),
      .rst        (Reset_In),
      .step_en    (step_en[i]),
      .up         (Up_Downb_In),
      .load       (Load_In),
      .load_digit (ld),
      .digit      (Count_Out[4*i +: 4]),
      .at_max     (at_max[i]),
      .at_min     (at_min[i])
    );
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      carry_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      carry_q <= ~Load_In & count_en & terminal;
      lerr_q  <= Load_In & (|ovr);
    end
  end

  assign Carry_Out      = carry_q;
  assign Load_Error_Out = lerr_q;
  assign Terminal_Out   = terminal;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: wrap and saturate builds.
// Decimal model checked every cycle plus literal checks.
module tb_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] lv = 8'h00;

  logic [7:0] cnt_w, cnt_s;
  logic       car_w, car_s;
  logic       trm_w, trm_s;
  logic       ler_w, ler_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.NUM_DIGITS(2), .WRAP_EN(1'b1)) dut_w (
    .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start),
    .Up_Downb_In(up), .Load_In(load), .Load_Value_In(lv),
    .Count_Out(cnt_w), .Carry_Out(car_w),
    .Terminal_Out(trm_w), .Load_Error_Out(ler_w)
  );

  bcd_cascade_counter #(.NUM_DIGITS(2), .WRAP_EN(1'b0)) dut_s (
    .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start),
    .Up_Downb_In(up), .Load_In(load), .Load_Value_In(lv),
    .Count_Out(cnt_s), .Carry_Out(car_s),
    .Terminal_Out(trm_s), .Load_Error_Out(ler_s)
  );

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  // Model: count as a plain integer 0..99; index 0 wraps, 1 saturates.
  int m_cnt [2];
  bit m_car [2];
  bit m_ler [2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int hi, lo;
      hi = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
      lo = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
      if (rst) begin
        m_cnt[k] <= 0;
        m_car[k] <= 1'b0;
        m_ler[k] <= 1'b0;
      end else if (load) begin
        m_cnt[k] <= hi * 10 + lo;
        m_car[k] <= 1'b0;
        m_ler[k] <= (lv[7:4] > 4'd9) || (lv[3:0] > 4'd9);
      end else begin
        m_ler[k] <= 1'b0;
        m_car[k] <= 1'b0;
        if (start && up) begin
          if (m_cnt[k] < 99) m_cnt[k] <= m_cnt[k] + 1;
          else if (k == 0) begin
            m_cnt[k] <= 0;
            m_car[k] <= 1'b1;
          end
        end else if (start && !up) begin
          if (m_cnt[k] > 0) m_cnt[k] <= m_cnt[k] - 1;
          else if (k == 0) begin
            m_cnt[k] <= 99;
            m_car[k] <= 1'b1;
          end
        end
      end
    end
    if (rst) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit tw, ts;
      tw = up ? (m_cnt[0] == 99) : (m_cnt[0] == 0);
      ts = up ? (m_cnt[1] == 99) : (m_cnt[1] == 0);
      chk("w_count", cnt_w, to_bcd(m_cnt[0]));
      chk("w_carry", {7'd0, car_w}, {7'd0, m_car[0]});
      chk("w_term", {7'd0, trm_w}, {7'd0, tw});
      chk("w_lerr", {7'd0, ler_w}, {7'd0, m_ler[0]});
      chk("s_count", cnt_s, to_bcd(m_cnt[1]));
      chk("s_carry", {7'd0, car_s}, {7'd0, m_car[1]});
      chk("s_term", {7'd0, trm_s}, {7'd0, ts});
      chk("s_lerr", {7'd0, ler_s}, {7'd0, m_ler[1]});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    lv = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    // 1: reset then run up through the wrap
    #1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("lit_reset_cnt", cnt_w, 8'h00);
    chk("lit_reset_car", {7'd0, car_w}, 8'h00);
    start = 1'b1;
    up = 1'b1;
    cyc(9);
    chk("lit_up_09", cnt_w, 8'h09);
    cyc();
    chk("lit_up_10", cnt_w, 8'h10);
    cyc(89);
    chk("lit_up_99", cnt_w, 8'h99);
    chk("lit_term_99", {7'd0, trm_w}, 8'h01);
    cyc();
    chk("lit_wrap_00", cnt_w, 8'h00);
    chk("lit_wrap_car", {7'd0, car_w}, 8'h01);
    chk("lit_sat_hold", cnt_s, 8'h99);
    cyc();
    chk("lit_car_drop", {7'd0, car_w}, 8'h00);

    // 2: down count and borrow
    do_load(8'h01);
    chk("lit_ld_01", cnt_w, 8'h01);
    up = 1'b0;
    cyc();
    chk("lit_dn_00", cnt_w, 8'h00);
    chk("lit_term_00", {7'd0, trm_w}, 8'h01);
    cyc();
    chk("lit_borrow_99", cnt_w, 8'h99);
    chk("lit_borrow_car", {7'd0, car_w}, 8'h01);
    chk("lit_sat_min", cnt_s, 8'h00);
    cyc();
    chk("lit_dn_98", cnt_w, 8'h98);

    // 3: saturate, then reverse direction
    up = 1'b1;
    do_load(8'h98);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lit_sat_99", cnt_s, 8'h99);
      chk("lit_sat_car", {7'd0, car_s}, 8'h00);
    end
    up = 1'b0;
    cyc();
    chk("lit_sat_rev", cnt_s, 8'h98);

    // 4: load clamp and error pulse
    start = 1'b0;
    do_load(8'hA7);
    chk("lit_clamp", cnt_w, 8'h97);
    chk("lit_lerr", {7'd0, ler_w}, 8'h01);
    cyc();
    chk("lit_lerr_drop", {7'd0, ler_w}, 8'h00);
    do_load(8'h3F);
    chk("lit_clamp_lo", cnt_w, 8'h39);
    do_load(8'h37);
    chk("lit_ld_37", cnt_w, 8'h37);
    chk("lit_no_lerr", {7'd0, ler_w}, 8'h00);

    // 5: stop, load while stopped, reset beats load
    do_load(8'h42);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lit_hold_42", cnt_w, 8'h42);
    end
    do_load(8'h15);
    chk("lit_ld_15", cnt_w, 8'h15);
    rst = 1'b1;
    load = 1'b1;
    lv = 8'hA7;
    cyc();
    rst = 1'b0;
    load = 1'b0;
    chk("lit_rst_cnt", cnt_w, 8'h00);
    chk("lit_rst_lerr", {7'd0, ler_w}, 8'h00);

    // 6: direction flip at 09
    start = 1'b1;
    up = 1'b1;
    do_load(8'h08);
    cyc();
    chk("lit_flip_09", cnt_w, 8'h09);
    up = 1'b0;
    cyc();
    chk("lit_flip_08", cnt_w, 8'h08);
    cyc();
    chk("lit_flip_07", cnt_w, 8'h07);

    // load coincident with a wrap: load wins, no carry
    up = 1'b1;
    do_load(8'h99);
    do_load(8'h50);
    chk("lit_ldwrap_cnt", cnt_w, 8'h50);
    chk("lit_ldwrap_car", {7'd0, car_w}, 8'h00);
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
